// File: rtl/inst_mem_pkg.sv
// Shared constants and the response record for the instruction memory pipe.
package inst_mem_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          RSP_INST_W = 32;

  // Packed layout {inst, err} is also the bit layout of the response buffer word.
  typedef struct packed {
    logic [RSP_INST_W-1:0] inst;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry ordered response buffer. The owner never pushes when full and
// never pops when empty.
module rsp_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] buf_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) buf_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = buf_q[rd_ptr_q];

endmodule

// File: rtl/inst_mem_pipe.sv
// Instruction memory with a synchronous-read fetch pipe and a program-load
// port. Optional per-word even parity is enabled by defining INST_MEM_PARITY_EN.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a presented response holds
// (valid, inst, err) until it is taken.
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 5,
  parameter int    INST_W     = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  Req_valid,
  output logic                  Req_ready,
  input  logic [31:0]           Req_addr,
  output logic                  Rsp_valid,
  input  logic                  Rsp_ready,
  output logic [INST_W-1:0]     Rsp_inst,
  output logic                  Rsp_err,
  input  logic                  Ld_en,
  input  logic [DEPTH_LOG2-1:0] Ld_addr,
  input  logic [INST_W-1:0]     Ld_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef INST_MEM_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif
  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  typedef logic [DEPTH-1:0][MEM_W-1:0] image_t;

  function automatic logic [MEM_W-1:0] pack_word(input logic [INST_W-1:0] w);
`ifdef INST_MEM_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic image_t load_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = pack_word(NOP_W);
    return img;
  endfunction

  // Storage has no reset so the program survives Clrn.
  image_t mem_q = load_image();

  always_ff @(posedge Clk) begin
    if (Ld_en) mem_q[Ld_addr] <= pack_word(Ld_data);
  end

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_aerr;
  logic                  accept;
  logic                  pop;

  assign req_idx  = Req_addr[DEPTH_LOG2+1:2];
  assign req_aerr = (Req_addr[1:0] != 2'b00) ||
                    ((Req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  logic             ready_en_q;
  logic [1:0]       occ_q, occ_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_aerr_q, rd_aerr_d;
  logic [MEM_W-1:0] rd_word_q, rd_word_d;

  always_comb begin
    rd_valid_d = accept;
    rd_aerr_d  = rd_aerr_q;
    rd_word_d  = rd_word_q;
    if (accept) begin
      rd_aerr_d = req_aerr;
      rd_word_d = mem_q[req_idx];
    end
    occ_d = occ_q + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      ready_en_q <= 1'b0;
      occ_q      <= 2'd0;
      rd_valid_q <= 1'b0;
      rd_aerr_q  <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      occ_q      <= occ_d;
      rd_valid_q <= rd_valid_d;
      rd_aerr_q  <= rd_aerr_d;
      rd_word_q  <= rd_word_d;
    end
  end

  logic rd_par_bad;
`ifdef INST_MEM_PARITY_EN
  assign rd_par_bad = ^rd_word_q;
`else
  assign rd_par_bad = 1'b0;
`endif

  logic [INST_W:0] rd_rsp;
  logic [INST_W:0] fifo_head;
  logic [INST_W:0] head;
  logic            fifo_valid;
  logic            fifo_push;
  logic            fifo_pop;

  assign rd_rsp = {(rd_aerr_q ? NOP_W : rd_word_q[INST_W-1:0]), rd_aerr_q | rd_par_bad};

  // The fresh read bypasses the buffer only when it is taken on its first cycle.
  assign fifo_push = rd_valid_q & (fifo_valid | ~Rsp_ready);
  assign fifo_pop  = fifo_valid & Rsp_ready;

  rsp_fifo2 #(.W(INST_W + 1)) u_rsp_fifo2 (
    .clk_i       (Clk),
    .rst_ni      (Clrn),
    .push_i      (fifo_push),
    .push_data_i (rd_rsp),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head)
  );

  assign head      = fifo_valid ? fifo_head : rd_rsp;
  assign Rsp_valid = fifo_valid | rd_valid_q;
  assign Rsp_inst  = Rsp_valid ? head[INST_W:1] : '0;
  assign Rsp_err   = Rsp_valid & head[0];
  assign pop       = Rsp_valid & Rsp_ready;

  assign Req_ready = ready_en_q & (occ_q != 2'd2);
  assign accept    = Req_valid & Req_ready;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: directed vector table, hand sequences for
// backpressure and reset, randomized traffic against a reference model.
module tb_inst_mem_pipe;
  import inst_mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic        Req_valid;
  logic        Req_ready;
  logic [31:0] Req_addr;
  logic        Rsp_valid;
  logic        Rsp_ready;
  logic [31:0] Rsp_inst;
  logic        Rsp_err;
  logic        Ld_en;
  logic [4:0]  Ld_addr;
  logic [31:0] Ld_data;

  inst_mem_pipe dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .Req_valid (Req_valid),
    .Req_ready (Req_ready),
    .Req_addr  (Req_addr),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Rsp_inst  (Rsp_inst),
    .Rsp_err   (Rsp_err),
    .Ld_en     (Ld_en),
    .Ld_addr   (Ld_addr),
    .Ld_data   (Ld_data)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [32:0] exp_q [$];
  logic [31:0] ref_mem [32];
  bit          par_bad [32];
  bit          warm = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected response from the fetch rules: alignment, range, stored word.
  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    logic [4:0] w;
    if (a[1:0] != 2'b00 || a >= 32'd128) return {NOP_INST, 1'b1};
    w = a[6:2];
    return {ref_mem[w], par_bad[w]};
  endfunction

  // Outputs are sampled on the falling edge; the model is then advanced to
  // what the next rising edge will do.
  always @(negedge Clk) begin
    if (!Clrn) begin
      exp_q.delete();
      warm = 1'b0;
      check("rst_rsp_valid", 64'(Rsp_valid), 64'(0));
      check("rst_rsp_inst",  64'(Rsp_inst),  64'(0));
      check("rst_rsp_err",   64'(Rsp_err),   64'(0));
      check("rst_req_ready", 64'(Req_ready), 64'(0));
      if (Ld_en) begin ref_mem[Ld_addr] = Ld_data; par_bad[Ld_addr] = 1'b0; end
    end else begin
      bit exp_rdy;
      exp_rdy = warm && (exp_q.size() < 2);
      check("mon_req_ready", 64'(Req_ready), 64'(exp_rdy));
      check("mon_rsp_valid", 64'(Rsp_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("mon_rsp_data", 64'({Rsp_inst, Rsp_err}), 64'(exp_q[0]));
        if (Rsp_ready) void'(exp_q.pop_front());
      end
      if (exp_rdy && Req_valid) exp_q.push_back(model_fetch(Req_addr));
      if (Ld_en) begin ref_mem[Ld_addr] = Ld_data; par_bad[Ld_addr] = 1'b0; end
      warm = 1'b1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] addr;
    rsp_t        exp;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic le, input logic [4:0] la, input logic [31:0] ld,
                              input logic [31:0] a, input logic [31:0] ei, input logic ee);
    vec_t v;
    v.ld_en = le; v.ld_addr = la; v.ld_data = ld; v.addr = a;
    v.exp.inst = ei; v.exp.err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    @(posedge Clk); #1;
    Ld_en = 1'b1; Ld_addr = a; Ld_data = d;
    @(posedge Clk); #1;
    Ld_en = 1'b0;
  endtask

  task automatic fetch(input vec_t v, output rsp_t got, output int lat, output bit ok);
    int budget;
    @(posedge Clk); #1;
    Req_valid = 1'b1; Req_addr = v.addr; Rsp_ready = 1'b1;
    Ld_en = v.ld_en; Ld_addr = v.ld_addr; Ld_data = v.ld_data;
    budget = 20;
    while (!Req_ready && budget > 0) begin @(posedge Clk); #1; budget--; end
    ok = Req_ready;
    @(posedge Clk); #1;
    Req_valid = 1'b0; Ld_en = 1'b0;
    lat = 1;
    while (!Rsp_valid && lat < 20) begin @(posedge Clk); #1; lat++; end
    got.inst = Rsp_inst; got.err = Rsp_err;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rsp_t got;
    int   lat;
    bit   ok;
    logic [31:0] w;
    int   kind;

    for (int i = 0; i < 32; i++) begin ref_mem[i] = NOP_INST; par_bad[i] = 1'b0; end
    Clrn = 1'b1; Req_valid = 1'b0; Req_addr = '0; Rsp_ready = 1'b0;
    Ld_en = 1'b0; Ld_addr = '0; Ld_data = '0;
    #2 Clrn = 1'b0;
    #1;
    check("reset_rsp_valid", 64'(Rsp_valid), 64'(0));
    check("reset_rsp_inst",  64'(Rsp_inst),  64'(0));
    check("reset_rsp_err",   64'(Rsp_err),   64'(0));
    check("reset_req_ready", 64'(Req_ready), 64'(0));
    repeat (3) @(posedge Clk);
    #1 Clrn = 1'b1;
    check("ready_before_first_edge", 64'(Req_ready), 64'(0));
    @(posedge Clk); #1;
    check("ready_after_first_edge", 64'(Req_ready), 64'(1));

    load_word(5'd0,  32'h3401_000A);
    load_word(5'd1,  32'h1234_5678);
    load_word(5'd2,  32'hA5A5_0002);
    load_word(5'd3,  32'h0000_0001);
    load_word(5'd31, 32'hCAFE_F00D);

    vecs[0]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_0000, 32'h3401_000A, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_0002, 32'h0,         1'b1);
    vecs[2]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_0080, 32'h0,         1'b1);
    vecs[3]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_0004, 32'h1234_5678, 1'b0);
    vecs[4]  = mk(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0000_000C, 32'h0000_0001, 1'b0);
    vecs[5]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
    vecs[6]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_007C, 32'hCAFE_F00D, 1'b0);
    vecs[7]  = mk(1'b0, 5'd0, 32'h0,         32'h0000_007F, 32'h0,         1'b1);
    vecs[8]  = mk(1'b0, 5'd0, 32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1);
    vecs[9]  = mk(1'b1, 5'd5, 32'h5555_AAAA, 32'h0000_0014, 32'h0,         1'b0);
    vecs[10] = mk(1'b0, 5'd0, 32'h0,         32'h0000_0014, 32'h5555_AAAA, 1'b0);
    vecs[11] = mk(1'b0, 5'd0, 32'h0,         32'h0000_0008, 32'hA5A5_0002, 1'b0);

    foreach (vecs[i]) begin
      fetch(vecs[i], got, lat, ok);
      check($sformatf("tbl%0d_accept", i),  64'(ok),       64'(1));
      check($sformatf("tbl%0d_latency", i), 64'(lat),      64'(1));
      check($sformatf("tbl%0d_inst", i),    64'(got.inst), 64'(vecs[i].exp.inst));
      check($sformatf("tbl%0d_err", i),     64'(got.err),  64'(vecs[i].exp.err));
    end

    // Back-to-back with the consumer stalled, then drain.
    @(posedge Clk); #1;
    Rsp_ready = 1'b0; Req_valid = 1'b1; Req_addr = 32'h0;
    @(posedge Clk); #1; Req_addr = 32'h4;
    @(posedge Clk); #1; Req_addr = 32'h8;
    check("b2b_ready_full", 64'(Req_ready), 64'(0));
    repeat (3) @(posedge Clk);
    #1;
    check("b2b_ready_hold", 64'(Req_ready), 64'(0));
    check("b2b_head_hold",  64'(Rsp_inst),  64'(32'h3401_000A));
    Rsp_ready = 1'b1;
    @(posedge Clk); #1;
    check("b2b_ready_after_pop", 64'(Req_ready), 64'(1));
    check("b2b_second_inst",     64'(Rsp_inst),  64'(32'h1234_5678));
    @(posedge Clk); #1;
    Req_valid = 1'b0;
    check("b2b_third_valid", 64'(Rsp_valid), 64'(1));
    check("b2b_third_inst",  64'(Rsp_inst),  64'(32'hA5A5_0002));
    @(posedge Clk); #1;
    check("b2b_drained", 64'(Rsp_valid), 64'(0));

    // Reset with two items outstanding.
    Rsp_ready = 1'b0; Req_valid = 1'b1; Req_addr = 32'hC;
    @(posedge Clk); #1; Req_addr = 32'h0;
    @(posedge Clk); #1; Req_valid = 1'b0;
    check("rst_mid_pre_valid", 64'(Rsp_valid), 64'(1));
    Clrn = 1'b0;
    #1;
    check("rst_mid_valid", 64'(Rsp_valid), 64'(0));
    check("rst_mid_inst",  64'(Rsp_inst),  64'(0));
    check("rst_mid_ready", 64'(Req_ready), 64'(0));
    repeat (2) @(posedge Clk);
    #1 Clrn = 1'b1; Rsp_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_no_stale", 64'(Rsp_valid), 64'(0));
    fetch(mk(1'b0, 5'd0, 32'h0, 32'hC, 32'h0, 1'b0), got, lat, ok);
    check("rst_mem_kept", 64'(got.inst), 64'(32'hDEAD_BEEF));
    check("rst_mem_err",  64'(got.err),  64'(0));

`ifdef INST_MEM_PARITY_EN
    @(posedge Clk); #1;
    dut.mem_q[1][0] = ~dut.mem_q[1][0];
    ref_mem[1][0] = ~ref_mem[1][0];
    par_bad[1] = 1'b1;
    fetch(mk(1'b0, 5'd0, 32'h0, 32'h4, 32'h0, 1'b0), got, lat, ok);
    check("parity_err",  64'(got.err),  64'(1));
    check("parity_inst", 64'(got.inst), 64'(32'h1234_5679));
    load_word(5'd1, 32'h1234_5678);
`endif

    // Randomized traffic; the monitor model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      @(posedge Clk); #1;
      Req_valid = ($urandom_range(0, 3) != 0);
      w = 32'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      Req_addr = w * 32'd4 + 32'($urandom_range(1, 3));
      else if (kind == 1) Req_addr = 32'd128 + 32'($urandom_range(0, 4095)) * 32'd4;
      else if (kind == 2) Req_addr = $urandom | 32'h8000_0000;
      else                Req_addr = w * 32'd4;
      Rsp_ready = ($urandom_range(0, 2) != 0);
      Ld_en   = ($urandom_range(0, 7) == 0);
      Ld_addr = 5'($urandom_range(0, 31));
      Ld_data = $urandom;
    end
    @(posedge Clk); #1;
    Req_valid = 1'b0; Ld_en = 1'b0; Rsp_ready = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("final_drained", 64'(Rsp_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
